// File: rtl/duc_hb_cascade_n_pkg.sv
// Shared types and constants for the half-band interpolation cascade.
package duc_hb_cascade_n_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_RESTART
    } state_t;

    // Input samples between a FIR pull and that sample reaching the center-tap output.
    localparam int unsigned HB_STAGE_LATENCY = 2;

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned num_stages);
        return (k > num_stages) ? num_stages : k;
    endfunction

endpackage

// File: rtl/duc_hb_interp_fir_h0.sv
// Pull-driven 2x half-band interpolator, taps [-1 9 16 9 -1]/16, unity DC gain.
module duc_hb_interp_fir_h0 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_inph_data,
    input  logic [WIDTH-1:0] i_quad_data,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_inph_data,
    output logic [WIDTH-1:0] o_quad_data,
    input  logic             i_ready
);

    localparam logic signed [WIDTH+4:0] SAT_MAX = {6'b000000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+4:0] SAT_MIN = {6'b111111, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] di [4];
    logic [WIDTH-1:0] dq [4];
    logic             phase;

    function automatic logic [WIDTH-1:0] interp(
        input logic [WIDTH-1:0] outer_new,
        input logic [WIDTH-1:0] inner_new,
        input logic [WIDTH-1:0] inner_old,
        input logic [WIDTH-1:0] outer_old
    );
        logic signed [WIDTH+4:0] e0, e1, e2, e3, acc, q;
        e0  = {{5{outer_new[WIDTH-1]}}, outer_new};
        e1  = {{5{inner_new[WIDTH-1]}}, inner_new};
        e2  = {{5{inner_old[WIDTH-1]}}, inner_old};
        e3  = {{5{outer_old[WIDTH-1]}}, outer_old};
        acc = (e1 <<< 3) + e1 + (e2 <<< 3) + e2 - e0 - e3;
        q   = acc >>> 4;
        if (q > SAT_MAX) begin
            q = SAT_MAX;
        end else if (q < SAT_MIN) begin
            q = SAT_MIN;
        end
        return q[WIDTH-1:0];
    endfunction

    // Phase 0 emits the center tap, phase 1 the midpoint; a new sample is pulled after phase 1.
    assign o_ready     = i_ready && phase;
    assign o_inph_data = phase ? interp(di[0], di[1], di[2], di[3]) : di[2];
    assign o_quad_data = phase ? interp(dq[0], dq[1], dq[2], dq[3]) : dq[2];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            phase <= 1'b0;
            for (int unsigned n = 0; n < 4; n++) begin
                di[n] <= '0;
                dq[n] <= '0;
            end
        end else if (i_ready) begin
            phase <= ~phase;
            if (phase) begin
                di[0] <= i_inph_data;
                dq[0] <= i_quad_data;
                for (int unsigned n = 1; n < 4; n++) begin
                    di[n] <= di[n-1];
                    dq[n] <= dq[n-1];
                end
            end
        end
    end

endmodule

// File: rtl/duc_hb_stage_bypass.sv
// One cascade stage: FIR plus output skid, with the FIR skipped and held in reset when bypassed.
module duc_hb_stage_bypass #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_stage_reset,
    input  logic             i_bypass,
    input  logic [WIDTH-1:0] i_inph_data,
    input  logic [WIDTH-1:0] i_quad_data,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_inph_data,
    output logic [WIDTH-1:0] o_quad_data,
    input  logic             i_ready
);

    logic             fir_reset;
    logic             fir_pull;
    logic             fir_ready;
    logic             skid_ready;
    logic [WIDTH-1:0] fir_inph;
    logic [WIDTH-1:0] fir_quad;
    logic [WIDTH-1:0] skid_inph;
    logic [WIDTH-1:0] skid_quad;

    assign fir_reset = i_stage_reset || i_bypass;
    assign fir_pull  = skid_ready && !i_bypass;

    duc_hb_interp_fir_h0 #(.WIDTH(WIDTH)) u_fir (
        .i_clock     (i_clock),
        .i_reset     (fir_reset),
        .i_inph_data (i_inph_data),
        .i_quad_data (i_quad_data),
        .o_ready     (fir_ready),
        .o_inph_data (fir_inph),
        .o_quad_data (fir_quad),
        .i_ready     (fir_pull)
    );

    assign skid_inph = i_bypass ? i_inph_data : fir_inph;
    assign skid_quad = i_bypass ? i_quad_data : fir_quad;

    duc_skid #(.WIDTH(WIDTH)) u_skid (
        .i_clock     (i_clock),
        .i_reset     (i_stage_reset),
        .i_inph_data (skid_inph),
        .i_quad_data (skid_quad),
        .o_ready     (skid_ready),
        .o_inph_data (o_inph_data),
        .o_quad_data (o_quad_data),
        .i_ready     (i_ready)
    );

    assign o_ready = i_bypass ? skid_ready : fir_ready;

endmodule

// File: rtl/duc_skid.sv
// Two-entry pull skid buffer: registered upstream ready, registered output data.
module duc_skid #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_inph_data,
    input  logic [WIDTH-1:0] i_quad_data,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_inph_data,
    output logic [WIDTH-1:0] o_quad_data,
    input  logic             i_ready
);

    logic [2*WIDTH-1:0] entry [2];
    logic [1:0]         count;
    logic [1:0]         count_next;
    logic               ready_q;
    logic               pop;
    logic               push;
    logic               wr_slot;

    always_comb begin
        pop        = i_ready && (count != 2'd0);
        push       = ready_q;
        count_next = count + {1'b0, push} - {1'b0, pop};
        // Pushing at count 2 cannot happen: ready_q is only set when room remains.
        wr_slot    = (count == 2'd2) || ((count == 2'd1) && !pop);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count    <= '0;
            ready_q  <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next < 2'd2);
            if (pop) begin
                entry[0] <= entry[1];
            end
            if (push) begin
                if (wr_slot) begin
                    entry[1] <= {i_inph_data, i_quad_data};
                end else begin
                    entry[0] <= {i_inph_data, i_quad_data};
                end
            end
        end
    end

    assign o_ready     = ready_q;
    assign o_inph_data = (count != 2'd0) ? entry[0][2*WIDTH-1:WIDTH] : '0;
    assign o_quad_data = (count != 2'd0) ? entry[0][WIDTH-1:0]       : '0;

endmodule

// File: rtl/duc_hb_cascade_n.sv
// Half-band interpolation cascade with run-time active-stage count and flush/restart on rate change.
module duc_hb_cascade_n
    import duc_hb_cascade_n_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned RESTART_CYCLES = 4
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [$clog2(NUM_STAGES+1)-1:0]   i_num_active,
    input  logic [WIDTH-1:0]                  i_inph_data,
    input  logic [WIDTH-1:0]                  i_quad_data,
    output logic                              o_ready,
    output logic [WIDTH-1:0]                  o_inph_data,
    output logic [WIDTH-1:0]                  o_quad_data,
    input  logic                              i_ready,
    output logic                              o_busy,
    output logic [$clog2(NUM_STAGES+1)-1:0]   o_num_active
);

    localparam int unsigned K_W   = $clog2(NUM_STAGES + 1);
    localparam int unsigned CNT_W = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [K_W-1:0]      k_req;
    logic [K_W-1:0]      k_cur;
    logic                run;
    logic                stage_reset;
    logic [NUM_STAGES-1:0] bypass;
    logic [NUM_STAGES:0] ready_chain;
    logic [WIDTH-1:0]    chain_i [NUM_STAGES+1];
    logic [WIDTH-1:0]    chain_q [NUM_STAGES+1];

    assign k_req = K_W'(clamp_k(32'(i_num_active), NUM_STAGES));

    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN:     if (k_req != k_cur) state_next = ST_DRAIN;
            ST_DRAIN:   state_next = ST_RESTART;
            ST_RESTART: if (cnt == '0) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    // k is latched on the RUN->DRAIN edge so the new value is visible during DRAIN itself.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_RUN;
            k_cur <= k_req;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_RUN) && (state_next == ST_DRAIN)) begin
                k_cur <= k_req;
            end
            if ((state == ST_DRAIN) && (state_next == ST_RESTART)) begin
                cnt <= CNT_W'(RESTART_CYCLES - 1);
            end else if ((state == ST_RESTART) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign run         = (state == ST_RUN);
    assign stage_reset = i_reset || (state == ST_RESTART);

    always_comb begin
        bypass = '0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            bypass[s] = (s >= 32'(k_cur));
        end
    end

    assign chain_i[0]              = i_inph_data;
    assign chain_q[0]              = i_quad_data;
    assign ready_chain[NUM_STAGES] = i_ready && run;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        duc_hb_stage_bypass #(.WIDTH(WIDTH)) u_stage (
            .i_clock       (i_clock),
            .i_stage_reset (stage_reset),
            .i_bypass      (bypass[s]),
            .i_inph_data   (chain_i[s]),
            .i_quad_data   (chain_q[s]),
            .o_ready       (ready_chain[s]),
            .o_inph_data   (chain_i[s+1]),
            .o_quad_data   (chain_q[s+1]),
            .i_ready       (ready_chain[s+1])
        );
    end

    assign o_ready      = ready_chain[0] && run;
    assign o_inph_data  = run ? chain_i[NUM_STAGES] : '0;
    assign o_quad_data  = run ? chain_q[NUM_STAGES] : '0;
    assign o_busy       = !run;
    assign o_num_active = k_cur;

endmodule

// File: tb/tb_duc_hb_cascade_n.sv
// Directed bench for duc_hb_cascade_n: DC gain/rate table, k=0 ramp, random stalls, rate change, reset.
module tb_duc_hb_cascade_n;
    import duc_hb_cascade_n_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned NS = 3;
    localparam int unsigned RC = 4;
    localparam int unsigned KW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KW-1:0] num_active = KW'(3);
    logic [W-1:0]  in_i = '0;
    logic [W-1:0]  in_q = '0;
    logic          src_ready;
    logic [W-1:0]  out_i;
    logic [W-1:0]  out_q;
    logic          sink_ready = 1'b1;
    logic          busy;
    logic [KW-1:0] num_applied;

    logic [2:0]    num_active_c = 3'd7;
    logic          src_ready_c;
    logic [W-1:0]  out_i_c;
    logic [W-1:0]  out_q_c;
    logic          busy_c;
    logic [2:0]    num_applied_c;

    int checks   = 0;
    int failures = 0;
    int busy_c_seen = 0;
    bit monitor_on = 1'b0;

    always #5 clk = ~clk;

    duc_hb_cascade_n #(.WIDTH(W), .NUM_STAGES(NS), .RESTART_CYCLES(RC)) dut (
        .i_clock(clk), .i_reset(rst), .i_num_active(num_active),
        .i_inph_data(in_i), .i_quad_data(in_q), .o_ready(src_ready),
        .o_inph_data(out_i), .o_quad_data(out_q), .i_ready(sink_ready),
        .o_busy(busy), .o_num_active(num_applied)
    );

    duc_hb_cascade_n #(.WIDTH(W), .NUM_STAGES(4), .RESTART_CYCLES(RC)) dut_clamp (
        .i_clock(clk), .i_reset(rst), .i_num_active(num_active_c),
        .i_inph_data(in_i), .i_quad_data(in_q), .o_ready(src_ready_c),
        .o_inph_data(out_i_c), .o_quad_data(out_q_c), .i_ready(sink_ready),
        .o_busy(busy_c), .o_num_active(num_applied_c)
    );

    always @(negedge clk) begin
        if (monitor_on && (busy_c === 1'b1)) busy_c_seen++;
    end

    typedef struct {
        int          k;
        logic [15:0] in_i;
        logic [15:0] in_q;
        logic [15:0] exp_i;
        logic [15:0] exp_q;
        int          pulses;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_reset(input int k);
        num_active = KW'(k);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        monitor_on = 1'b1;
    endtask

    task automatic window(input logic [15:0] ei, input logic [15:0] eq, output int pulses, output int mism, output int nbusy);
        pulses = 0; mism = 0; nbusy = 0;
        for (int n = 0; n < 64; n++) begin
            cycle();
            if (src_ready) pulses++;
            if (busy) nbusy++;
            if (out_i != ei || out_q != eq) mism++;
        end
    endtask

    int acc [160];
    int got_i [160];
    int got_q [160];

    initial begin
        int pulses, mism, nbusy, ins, outs, glitch, bad;
        logic [15:0] ramp;
        logic [5:0]  bpat;

        vecs[0] = '{3, 16'h1000, 16'hF000, 16'h1000, 16'hF000, 8};
        vecs[1] = '{2, 16'h0400, 16'hFC00, 16'h0400, 16'hFC00, 16};
        vecs[2] = '{1, 16'hE000, 16'h1230, 16'hE000, 16'h1230, 32};
        vecs[3] = '{0, 16'h1234, 16'h8001, 16'h1234, 16'h8001, 64};

        repeat (2) cycle();

        // DC gain and pull rate per active-stage count
        for (int r = 0; r < 4; r++) begin
            in_i = vecs[r].in_i;
            in_q = vecs[r].in_q;
            sink_ready = 1'b1;
            do_reset(vecs[r].k);
            check($sformatf("reset_ready_k%0d", vecs[r].k), src_ready, 0);
            check($sformatf("reset_out_i_k%0d", vecs[r].k), out_i, 0);
            check($sformatf("reset_out_q_k%0d", vecs[r].k), out_q, 0);
            check($sformatf("reset_busy_k%0d", vecs[r].k), busy, 0);
            check($sformatf("reset_num_k%0d", vecs[r].k), num_applied, vecs[r].k);
            repeat (200 + 16 * HB_STAGE_LATENCY) cycle();
            window(vecs[r].exp_i, vecs[r].exp_q, pulses, mism, nbusy);
            check($sformatf("dc_out_k%0d", vecs[r].k), mism, 0);
            check_range($sformatf("pull_rate_k%0d", vecs[r].k), pulses, vecs[r].pulses - 1, vecs[r].pulses + 1);
            check($sformatf("steady_busy_k%0d", vecs[r].k), nbusy, 0);
        end

        // k=0 ramp: pure 3-register pipeline
        sink_ready = 1'b1;
        in_i = '0; in_q = '0;
        do_reset(0);
        ramp = 16'h0100;
        for (int n = 0; n < 160; n++) begin
            cycle();
            got_i[n] = int'(out_i);
            got_q[n] = int'(out_q);
            in_i = ramp;
            in_q = -ramp;
            acc[n] = -1;
            if (src_ready) begin
                acc[n] = int'(ramp);
                ramp = ramp + 16'd1;
            end
        end
        mism = 0; pulses = 0;
        for (int n = 20; n < 160; n++) begin
            logic [15:0] v, nv;
            if (acc[n] >= 0) pulses++;
            if (acc[n-3] < 0) begin
                mism++;
            end else begin
                v  = 16'(acc[n-3]);
                nv = -v;
                if (got_i[n] != int'(v) || got_q[n] != int'(nv)) mism++;
            end
        end
        check("ramp_delay3", mism, 0);
        check("ramp_ready_every_cycle", pulses, 140);

        // k=2 with random downstream stalls
        in_i = 16'h0A00; in_q = 16'hF600;
        do_reset(2);
        ins = 0; outs = 0; glitch = 0;
        for (int n = 0; n < 1200; n++) begin
            cycle();
            sink_ready = 1'($urandom_range(0, 1));
            if (n >= 300) begin
                if (src_ready) ins++;
                if (sink_ready) begin
                    outs++;
                    if (out_i != 16'h0A00 || out_q != 16'hF600) glitch++;
                end
            end
        end
        check_range("rand_out_vs_4x_in", outs - 4 * ins, -24, 24);
        check("rand_dc_glitch", glitch, 0);

        // Rate change 3 -> 1 in RUN
        sink_ready = 1'b1;
        in_i = 16'h1000; in_q = 16'hF000;
        do_reset(3);
        repeat (100) cycle();
        num_active = KW'(1);
        bpat = '0; bad = 0;
        for (int j = 0; j < 6; j++) begin
            cycle();
            bpat[j] = busy;
            if (busy && (src_ready || out_i != 0 || out_q != 0)) bad++;
            if (j == 0) check("chg_num_at_t1", num_applied, 1);
        end
        check("chg_busy_pattern", bpat, 6'b011111);
        check("chg_quiet_while_busy", bad, 0);
        repeat (60) cycle();
        window(16'h1000, 16'hF000, pulses, mism, nbusy);
        check_range("chg_pull_rate_k1", pulses, 31, 33);
        check("chg_dc_out_k1", mism, 0);
        check("chg_no_repeat_flush", nbusy, 0);

        // Reset in the middle of RESTART
        do_reset(3);
        repeat (40) cycle();
        num_active = KW'(2);
        repeat (3) cycle();
        check("rst_precond_busy", busy, 1);
        num_active = KW'(1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ready", src_ready, 0);
        check("rst_out_i", out_i, 0);
        check("rst_out_q", out_q, 0);
        check("rst_num", num_applied, 1);
        repeat (60) cycle();
        window(16'h1000, 16'hF000, pulses, mism, nbusy);
        check_range("rst_pull_rate_k1", pulses, 31, 33);
        check("rst_dc_out_k1", mism, 0);
        check("rst_no_flush", nbusy, 0);

        // Out-of-range request on the 4-stage instance
        check("clamp_num", num_applied_c, 4);
        check("clamp_no_flush", busy_c_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
